// File: rtl/peripheral_datos_tx_pkg.sv
// Shared definitions for the data transmit peripheral: address map, frame
// header, sequencer state encoding and STATUS bit layout.
package peripheral_datos_tx_pkg;

  localparam int NFIELDS = 10;
  localparam logic [7:0] HEADER = 8'hAA;

  localparam logic [3:0] FIELD_BASE = 4'h0;
  localparam logic [3:0] CTRL_ADDR  = 4'hE;
  localparam logic [3:0] STAT_ADDR  = 4'hF;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int CTRL_START_BIT = 0;

  typedef enum logic [1:0] {IDLE, HDR, FIELD, CSUM} frame_state_t;

  typedef logic [7:0] field_arr_t [NFIELDS];

  // Unsigned subtraction wraps addresses below FIELD_BASE out of range too.
  function automatic logic is_field_addr(input logic [3:0] a);
    return (a - FIELD_BASE) <= 4'(NFIELDS - 1);
  endfunction

endpackage

// File: rtl/datos_frame_seq.sv
// Frame sequencer: emits HEADER, the field bytes in order and their mod-256
// sum over a valid/ready byte stream.
module datos_frame_seq
  import peripheral_datos_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  field_arr_t fields,
  input  logic       start,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_IDX = 4'(NFIELDS - 1);

  frame_state_t state;
  logic [3:0]   idx;
  logic [7:0]   csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      csum     <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= HDR;
            idx      <= '0;
            csum     <= '0;
            done     <= 1'b0;
            tx_data  <= HEADER;
            tx_valid <= 1'b1;
          end
        end
        HDR: begin
          if (tx_ready) begin
            state   <= FIELD;
            tx_data <= fields[0];
          end
        end
        FIELD: begin
          if (tx_ready) begin
            csum <= csum + tx_data;
            if (idx == LAST_IDX) begin
              // Checksum byte includes the field being accepted this edge.
              state   <= CSUM;
              tx_data <= csum + tx_data;
            end else begin
              idx     <= idx + 4'd1;
              tx_data <= fields[idx + 4'd1];
            end
          end
        end
        CSUM: begin
          if (tx_ready) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            done     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/peripheral_datos_tx.sv
// J1 bus peripheral holding ten byte-wide field registers that are sent as a
// framed byte stream when software writes the start bit.
module peripheral_datos_tx
  import peripheral_datos_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  field_arr_t field_q;
  logic       done;
  logic       start;
  logic       bus_wr;

  // Only the low byte of the bus carries register data.
  logic unused_d_in_hi;
  assign unused_d_in_hi = &{1'b0, d_in[15:8]};

  assign bus_wr = cs && wr;
  assign start  = bus_wr && (addr == CTRL_ADDR) && d_in[CTRL_START_BIT] && !busy;

  // Fields are frozen while a frame is in flight so the sequencer reads them live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NFIELDS; i++) field_q[i] <= '0;
    end else if (bus_wr && !busy && is_field_addr(addr)) begin
      field_q[addr - FIELD_BASE] <= d_in[7:0];
    end
  end

  always_comb begin
    d_out = '0;
    if (cs && rd) begin
      if (is_field_addr(addr)) begin
        d_out = {8'b0, field_q[addr - FIELD_BASE]};
      end else if (addr == STAT_ADDR) begin
        d_out[STAT_BUSY_BIT] = busy;
        d_out[STAT_DONE_BIT] = done;
      end
    end
  end

  datos_frame_seq u_seq (
    .clk      (clk),
    .rst      (rst),
    .fields   (field_q),
    .start    (start),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

endmodule
